// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_EXT
    } arb_owner_t;

    localparam int unsigned MEM_LAT_MIN = 1;

endpackage

// File: rtl/mem_arb_if.sv
// CPU, external-port and memory-side signal bundle of mem_port_arbiter.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] ext_rdata;
    logic          ext_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter timing the fixed memory latency; last flags count==1.
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    localparam int unsigned W = $clog2(MEM_LAT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(MEM_LAT);
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and external-port accesses onto one fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    mem_arb_if.slave bus
);

    if (MEM_LAT < MEM_LAT_MIN) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end

    arb_state_t    state;
    arb_owner_t    owner;
    arb_owner_t    winner;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          mem_en_q;
    logic          cpu_ack_q;
    logic          ext_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ext_rdata_q;
    logic          cnt_last;

`ifdef MEM_ARB_RR_EN
    arb_owner_t last_owner;

    // Reset to OWN_EXT so the CPU wins the first contended arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_EXT;
        end else if (state == ISSUE) begin
            last_owner <= owner;
        end
    end

    always_comb begin
        winner = OWN_CPU;
        if (bus.cpu_req && bus.ext_req) begin
            winner = (last_owner == OWN_CPU) ? OWN_EXT : OWN_CPU;
        end else if (!bus.cpu_req) begin
            winner = OWN_EXT;
        end
    end
`else
    always_comb begin
        winner = bus.cpu_req ? OWN_CPU : OWN_EXT;
    end
`endif

    mem_arb_lat_cnt #(
        .MEM_LAT(MEM_LAT)
    ) u_lat_cnt (
        .clk (clk),
        .rst (rst),
        .load(state == ISSUE),
        .dec (state == WAIT),
        .last(cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            mem_en_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            mem_en_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            ext_ack_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.ext_req) begin
                        owner     <= winner;
                        req_we    <= (winner == OWN_CPU) ? bus.cpu_we    : bus.ext_we;
                        req_addr  <= (winner == OWN_CPU) ? bus.cpu_addr  : bus.ext_addr;
                        req_wdata <= (winner == OWN_CPU) ? bus.cpu_wdata : bus.ext_wdata;
                        mem_en_q  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Read data and ack are registered here so both appear in RESP.
                    if (cnt_last) begin
                        if (owner == OWN_CPU) begin
                            cpu_ack_q <= 1'b1;
                            if (!req_we) cpu_rdata_q <= bus.mem_rdata;
                        end else begin
                            ext_ack_q <= 1'b1;
                            if (!req_we) ext_rdata_q <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = req_we;
    assign bus.mem_addr  = req_addr;
    assign bus.mem_wdata = req_wdata;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.ext_ack   = ext_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ext_rdata = ext_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s_cpu_req [2];
    logic        s_cpu_we  [2];
    logic [31:0] s_cpu_addr[2];
    logic [31:0] s_cpu_wd  [2];
    logic        s_ext_req [2];
    logic        s_ext_we  [2];
    logic [31:0] s_ext_addr[2];
    logic [31:0] s_ext_wd  [2];

    logic        w_cpu_ack  [2];
    logic        w_ext_ack  [2];
    logic        w_cpu_stall[2];
    logic        w_mem_en   [2];
    logic        w_mem_we   [2];
    logic [31:0] w_mem_addr [2];
    logic [31:0] w_cpu_rdata[2];
    logic [31:0] w_ext_rdata[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | a);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;

        mem_arb_if #(.AW(32), .DW(32)) ifc ();

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(ifc)
        );

        assign ifc.cpu_req   = s_cpu_req[g];
        assign ifc.cpu_we    = s_cpu_we[g];
        assign ifc.cpu_addr  = s_cpu_addr[g];
        assign ifc.cpu_wdata = s_cpu_wd[g];
        assign ifc.ext_req   = s_ext_req[g];
        assign ifc.ext_we    = s_ext_we[g];
        assign ifc.ext_addr  = s_ext_addr[g];
        assign ifc.ext_wdata = s_ext_wd[g];

        assign w_cpu_ack[g]   = ifc.cpu_ack;
        assign w_ext_ack[g]   = ifc.ext_ack;
        assign w_cpu_stall[g] = ifc.cpu_stall;
        assign w_mem_en[g]    = ifc.mem_en;
        assign w_mem_we[g]    = ifc.mem_we;
        assign w_mem_addr[g]  = ifc.mem_addr;
        assign w_cpu_rdata[g] = ifc.cpu_rdata;
        assign w_ext_rdata[g] = ifc.ext_rdata;

        // Fixed-latency memory: read data pops out LAT cycles after mem_en, junk otherwise.
        logic [31:0] mem [logic [31:0]];
        logic [31:0] pipe [LAT];
        always @(posedge clk) begin
            for (int i = int'(LAT) - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            if (ifc.mem_en && !ifc.mem_we)
                pipe[0] <= mem.exists(ifc.mem_addr) ? mem[ifc.mem_addr] : init_val(ifc.mem_addr);
            else
                pipe[0] <= 32'hBAD0_0000 ^ 32'(cyc);
            if (ifc.mem_en && ifc.mem_we) mem[ifc.mem_addr] = ifc.mem_wdata;
        end
        assign ifc.mem_rdata = pipe[LAT-1];

        int en_cnt = 0;
        always @(negedge clk) if (ifc.mem_en) en_cnt++;

        // Transaction model: k counts cycles since the grant (0 = free).
        int          k = 0;
        bit          m_ext = 1'b0;
        bit          last_ext = 1'b1;
        logic        m_we = 1'b0;
        logic [31:0] m_addr = '0;
        logic [31:0] m_wd = '0;
        logic [31:0] e_crd = '0;
        logic [31:0] e_erd = '0;
        logic [31:0] mm [logic [31:0]];

        always @(posedge clk) begin
            if (rst) begin
                k = 0; m_we = 1'b0; m_addr = '0; m_wd = '0;
                e_crd = '0; e_erd = '0; last_ext = 1'b1;
            end else begin
                if (k == int'(LAT) + 2) k = 0;
                else if (k > 0) k++;
                else if (s_cpu_req[g] || s_ext_req[g]) begin
`ifdef MEM_ARB_RR_EN
                    m_ext = (s_cpu_req[g] && s_ext_req[g]) ? !last_ext : s_ext_req[g];
`else
                    m_ext = !s_cpu_req[g];
`endif
                    last_ext = m_ext;
                    m_we   = m_ext ? s_ext_we[g]   : s_cpu_we[g];
                    m_addr = m_ext ? s_ext_addr[g] : s_cpu_addr[g];
                    m_wd   = m_ext ? s_ext_wd[g]   : s_cpu_wd[g];
                    if (m_we) mm[m_addr] = m_wd;
                    k = 1;
                end
                if (k == int'(LAT) + 2 && !m_we) begin
                    if (m_ext) e_erd = mm.exists(m_addr) ? mm[m_addr] : init_val(m_addr);
                    else       e_crd = mm.exists(m_addr) ? mm[m_addr] : init_val(m_addr);
                end
            end
        end

        always @(negedge clk) begin
            if (cyc > 0) begin
                automatic logic e_cack = (k == int'(LAT) + 2) && !m_ext;
                automatic logic e_eack = (k == int'(LAT) + 2) && m_ext;
                chk($sformatf("d%0d.mem_en", g),    32'(ifc.mem_en),    32'(k == 1));
                chk($sformatf("d%0d.cpu_ack", g),   32'(ifc.cpu_ack),   32'(e_cack));
                chk($sformatf("d%0d.ext_ack", g),   32'(ifc.ext_ack),   32'(e_eack));
                chk($sformatf("d%0d.cpu_stall", g), 32'(ifc.cpu_stall), 32'(s_cpu_req[g] & ~e_cack));
                chk($sformatf("d%0d.mem_we", g),    32'(ifc.mem_we),    32'(m_we));
                chk($sformatf("d%0d.mem_addr", g),  ifc.mem_addr,  m_addr);
                chk($sformatf("d%0d.mem_wdata", g), ifc.mem_wdata, m_wd);
                chk($sformatf("d%0d.cpu_rdata", g), ifc.cpu_rdata, e_crd);
                chk($sformatf("d%0d.ext_rdata", g), ifc.ext_rdata, e_erd);
            end
        end
    end

    // One requester issuing n accesses back to back; ack cycles are relative to the first request.
    task automatic run(input int d, input bit ext, input bit we, input int n,
                       input logic [31:0] a0, input logic [31:0] wd,
                       output int ack_c[4], output logic [31:0] rd_c[4],
                       output int stall_n, output int enwe_n, output int en_off);
        int start;
        start = cyc; stall_n = 0; enwe_n = 0; en_off = -1;
        for (int i = 0; i < 4; i++) begin ack_c[i] = -1; rd_c[i] = '0; end
        if (ext) begin
            s_ext_we[d] = we; s_ext_addr[d] = a0; s_ext_wd[d] = wd; s_ext_req[d] = 1'b1;
        end else begin
            s_cpu_we[d] = we; s_cpu_addr[d] = a0; s_cpu_wd[d] = wd; s_cpu_req[d] = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            bit got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (w_mem_en[d] && en_off < 0) en_off = cyc - start;
                if (w_mem_en[d] && w_mem_we[d]) enwe_n++;
                if (!ext && w_cpu_stall[d]) stall_n++;
                if (ext ? w_ext_ack[d] : w_cpu_ack[d]) begin
                    got = 1'b1;
                    ack_c[i] = cyc - start;
                    rd_c[i] = ext ? w_ext_rdata[d] : w_cpu_rdata[d];
                end
            end
            if (!got) chk($sformatf("ack_timeout d%0d ext%0d", d, ext), 32'(got), 32'd1);
            @(posedge clk); #1;
            if (i < n - 1) begin
                if (ext) s_ext_addr[d] = a0 + 32'(4 * (i + 1));
                else     s_cpu_addr[d] = a0 + 32'(4 * (i + 1));
            end else begin
                if (ext) s_ext_req[d] = 1'b0;
                else     s_cpu_req[d] = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac[4], ae[4];
        logic [31:0] rc[4], re[4];
        int sn, wn, eo, sn2, wn2, eo2, en0, acks;

        for (int d = 0; d < 2; d++) begin
            s_cpu_req[d] = 1'b0; s_cpu_we[d] = 1'b0; s_cpu_addr[d] = '0; s_cpu_wd[d] = '0;
            s_ext_req[d] = 1'b0; s_ext_we[d] = 1'b0; s_ext_addr[d] = '0; s_ext_wd[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_cpu_ack",   32'(w_cpu_ack[d]), 32'd0);
            chk("rst_ext_ack",   32'(w_ext_ack[d]), 32'd0);
            chk("rst_mem_en",    32'(w_mem_en[d]),  32'd0);
            chk("rst_mem_addr",  w_mem_addr[d],     32'd0);
            chk("rst_cpu_rdata", w_cpu_rdata[d],    32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // CPU read, MEM_LAT=1
        run(0, 0, 0, 1, 32'h10, '0, ac, rc, sn, wn, eo);
        chk("t1_ack_latency", 32'(ac[0]), 32'd3);
        chk("t1_rdata",       rc[0],      32'hDEAD_BEEF);
        chk("t1_stall_cycles", 32'(sn),   32'd3);
        chk("t1_mem_en_offset", 32'(eo),  32'd1);

        // External write then read-back, MEM_LAT=3
        run(1, 1, 1, 1, 32'h20, 32'h1234_5678, ae, re, sn, wn, eo);
        chk("t2_ack_latency", 32'(ae[0]), 32'd5);
        chk("t2_en_we_cycles", 32'(wn),   32'd1);
        chk("t2_ext_rdata_kept", w_ext_rdata[1], 32'd0);
        run(1, 1, 0, 1, 32'h20, '0, ae, re, sn, wn, eo);
        chk("t2_readback", re[0], 32'h1234_5678);

        // CPU streams three reads
        run(0, 0, 0, 3, 32'h0, '0, ac, rc, sn, wn, eo);
        chk("t3_ack0", 32'(ac[0]), 32'd3);
        chk("t3_ack1", 32'(ac[1]), 32'd7);
        chk("t3_ack2", 32'(ac[2]), 32'd11);
        chk("t3_rd0", rc[0], 32'hA5A5_0000);
        chk("t3_rd1", rc[1], 32'hA5A5_0004);
        chk("t3_rd2", rc[2], 32'hA5A5_0008);

        // Simultaneous single requests
        fork
            run(1, 0, 0, 1, 32'h100, '0, ac, rc, sn, wn, eo);
            run(1, 1, 0, 1, 32'h200, '0, ae, re, sn2, wn2, eo2);
        join
        chk("t4_cpu_ack", 32'(ac[0]), 32'd5);
        chk("t4_ext_ack", 32'(ae[0]), 32'd11);
        chk("t4_ext_rd",  re[0], 32'hA5A5_0200);

        // Four contended back-to-back transactions
        fork
            run(1, 0, 0, 2, 32'h100, '0, ac, rc, sn, wn, eo);
            run(1, 1, 0, 2, 32'h200, '0, ae, re, sn2, wn2, eo2);
        join
`ifdef MEM_ARB_RR_EN
        chk("t5_cpu_ack0", 32'(ac[0]), 32'd5);
        chk("t5_ext_ack0", 32'(ae[0]), 32'd11);
        chk("t5_cpu_ack1", 32'(ac[1]), 32'd17);
        chk("t5_ext_ack1", 32'(ae[1]), 32'd23);
`else
        chk("t5_cpu_ack0", 32'(ac[0]), 32'd5);
        chk("t5_cpu_ack1", 32'(ac[1]), 32'd11);
        chk("t5_ext_ack0", 32'(ae[0]), 32'd17);
        chk("t5_ext_ack1", 32'(ae[1]), 32'd23);
`endif
        chk("t5_cpu_rd1", rc[1], 32'hA5A5_0104);
        chk("t5_ext_rd1", re[1], 32'hA5A5_0204);

        // External request arriving while the CPU access is in WAIT
        en0 = gen_dut[1].en_cnt;
        fork
            run(1, 0, 0, 1, 32'h50, '0, ac, rc, sn, wn, eo);
            begin
                repeat (2) begin @(posedge clk); #1; end
                run(1, 1, 0, 1, 32'h60, '0, ae, re, sn2, wn2, eo2);
            end
        join
        chk("t6_cpu_ack", 32'(ac[0]), 32'd5);
        chk("t6_ext_ack", 32'(ae[0]), 32'd9);
        chk("t6_mem_en_pulses", 32'(gen_dut[1].en_cnt - en0), 32'd2);

        // Reset during WAIT abandons the access
        s_cpu_we[1] = 1'b0; s_cpu_addr[1] = 32'h40; s_cpu_req[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; s_cpu_req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t7_state_idle", 32'(gen_dut[1].u_dut.state), 32'(IDLE));
        chk("t7_mem_en",     32'(w_mem_en[1]), 32'd0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (w_cpu_ack[1] || w_ext_ack[1]) acks++;
            @(negedge clk);
        end
        chk("t7_no_ack", 32'(acks), 32'd0);
        @(posedge clk); #1;
        run(1, 0, 0, 1, 32'h44, '0, ac, rc, sn, wn, eo);
        chk("t7_after_ack", 32'(ac[0]), 32'd5);
        chk("t7_after_rd",  rc[0], 32'hA5A5_0044);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU (FETCH/MEMLW/MEMSW accesses of the controller FSM) and an external port (program loader/debug). A small FSM serializes accesses, issues them to a fixed-latency memory, and returns a one-cycle acknowledge with registered read data. The CPU-side `cpu_stall` lets the controller FSM hold its state until its access completes.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles; must be ≥1
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `cpu_req` in 1: CPU access request, level
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in AW: CPU address
- `cpu_wdata` in DW: CPU write data
- `cpu_rdata` out DW: read data, held until the next read completes
- `cpu_ack` out 1: one-cycle completion pulse
- `cpu_stall` out 1: `cpu_req & ~cpu_ack`, combinational
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_rdata`, `ext_ack`: same as the CPU set, for the external port
- `mem_en` out 1: memory access strobe, one cycle per transaction
- `mem_we` out 1: memory write enable, qualified by `mem_en`
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: memory read data, valid in cycle t+MEM_LAT when `mem_en` is high in cycle t

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is high, latch the winner as owner, and latch its `we`, `addr` and `wdata` into request registers; then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: one cycle. Drive `mem_en`=1, and drive `mem_we`, `mem_addr` and `mem_wdata` from the request registers. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter equals 1:
  - for a read, capture `mem_rdata` into the owner's rdata register;
  - go to RESP.
- RESP: one cycle. Assert the owner's ack. Always go to IDLE.
- Arbitration (default): fixed priority, CPU over external.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until ack.
  - After ack, the requester may keep `req` high; this is treated as a new transaction.
  - A requester dropping `req` before ack is a protocol violation. The latched transaction still completes.
- Writes follow the same timing as reads. rdata registers are untouched on writes.
- A request from the non-owner arriving during ISSUE/WAIT/RESP waits and is arbitrated in the next IDLE.
- `mem_en`=0 in every state except ISSUE. `mem_addr`, `mem_wdata` and `mem_we` always reflect the request registers.

## Timing
- Request high in IDLE cycle c: ISSUE in c+1, WAIT in c+2..c+1+MEM_LAT, ack in c+2+MEM_LAT.
- Latency from request to ack is MEM_LAT+2 cycles. Minimum spacing between transactions is MEM_LAT+3 cycles.
- `cpu_stall` is high from the cycle `cpu_req` rises through the cycle before `cpu_ack`. It is low in the ack cycle.
- Reset values:
  - state IDLE;
  - `mem_en`, `mem_we`, `cpu_ack`, `ext_ack` = 0;
  - `cpu_rdata`, `ext_rdata`, `mem_addr`, `mem_wdata` = 0;
  - counter 0;
  - round-robin pointer set so the CPU wins first.
- Reset mid-transaction: the FSM returns to IDLE at the reset edge, no ack is generated, and the in-flight access is abandoned. Requesters must re-request.
- Simultaneous requests in IDLE: exactly one grant per IDLE visit. There is never a double ack.

## Configuration
- `MEM_ARB_RR_EN`
  - Defined: round-robin arbitration. A 1-bit last-owner register is updated in ISSUE. On simultaneous requests, the requester not granted last wins.
  - Undefined: fixed CPU priority; no pointer register is implemented. The external port can starve while the CPU requests continuously.

## Structure
- Package `mem_arb_pkg`:
  - state typedef `arb_state_t` (IDLE/ISSUE/WAIT/RESP);
  - owner typedef `arb_owner_t` (OWN_CPU/OWN_EXT);
  - the MEM_LAT ≥ 1 range check constant.
- One sub-module: `mem_arb_lat_cnt`, a loadable down-counter with load/decrement/`last` (count==1) outputs, sized `$clog2(MEM_LAT+1)`.

## Test plan
- CPU read, MEM_LAT=1, addr 0x10, memory model returns 0xDEADBEEF: `mem_en` pulses 1 cycle after the request, `cpu_ack` 3 cycles after the request, `cpu_rdata`=0xDEADBEEF, and `cpu_stall` is high for 3 cycles.
- External write, addr 0x20, data 0x12345678, MEM_LAT=3: `mem_we`=1 with `mem_en` for exactly one cycle, `ext_ack` 5 cycles after the request, `ext_rdata` unchanged.
- Both requests high in the same IDLE cycle:
  - default build: CPU acked first, external acked MEM_LAT+3 cycles later;
  - with `MEM_ARB_RR_EN`: alternate grants over 4 back-to-back contended transactions.
- CPU holds `cpu_req` high for 3 reads (0x0, 0x4, 0x8): exactly 3 acks, spaced MEM_LAT+3 cycles apart, each with the correct data.
- `rst` asserted in WAIT: no ack, `mem_en`=0, and state is IDLE the cycle after reset. A subsequent request completes normally.
- External request arrives during a CPU WAIT: `ext_ack` occurs only after `cpu_ack`, and `mem_en` is never asserted twice within one transaction.
